dmem_responder: RTL and testbench

- Multi-cycle data memory responder on the CPU's memory access interface.
- The CPU datapath issues READ/WRITE requests with an ADDRESS and WRITEDATA, then stalls on BUSYWAIT.
- This block accepts the request, models a fixed access latency, commits the write or returns READDATA, and releases the stall.
- Sits beside the ALU/register-file datapath on the load/store path.

---
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: accepts one READ/WRITE, waits LATENCY cycles, commits.
// Optional macro DMEM_CLEAR_ON_RESET_EN clears the whole array while RESET is low.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy;
  logic                req;
  logic                commit_wr;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Both strobes high is an illegal request and is treated as no request at all.
  assign req       = READ ^ WRITE;
  assign commit_wr = (state_q == ACCESS) && (cnt_q == 8'd0) && wr_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = req;
        if (req) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
          wr_d    = WRITE;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = DONE;
          if (!wr_q) rdata_d = mem[addr_q];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The stall is combinational in IDLE, so it is forced low while reset is asserted.
  assign BUSYWAIT = RESET & busy;
  assign READDATA = rdata_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_wr) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset.
  always_ff @(posedge CLK) begin
    if (commit_wr) mem[addr_q] <= wdata_q;
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// checked against a transaction-level memory model.
module tb_dmem_responder;

  localparam int LAT = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rd    = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [256];
  bit         known     [256];
  logic [7:0] exp_rd;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .READ      (rd),
    .WRITE     (wr),
    .ADDRESS   (addr),
    .WRITEDATA (wdata),
    .READDATA  (rdata),
    .BUSYWAIT  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs at once, hold it for some edges, release.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    exp_rd = 8'h00;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'h00;
      known[i]     = 1'b1;
    end
`endif
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, exp_rd);
    repeat (cycles) tick();
    rd    = 1'b0;
    wr    = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  // Starts in IDLE just after an edge; returns just after the commit edge (DONE).
  task automatic request(input logic r, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input bit move_addr);
    int edges;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    #1;
    check("req_busy", busy, 1'b1);
    tick();
    if (move_addr) begin
      addr  = a ^ 8'h30;
      wdata = ~d;
    end
    edges = 0;
    while (busy === 1'b1 && edges < LAT + 8) begin
      check("hold_rdata", rdata, exp_rd);
      tick();
      edges++;
    end
    check("busy_edges", edges, LAT);
    if (r) exp_rd = model_mem[a];
    if (w) begin
      model_mem[a] = d;
      known[a]     = 1'b1;
    end
    check("commit_rdata", rdata, exp_rd);
  endtask

  // From DONE: either drop the request or keep READ asserted for the next address.
  task automatic release_req(input bit hold, input logic [7:0] next_a);
    if (hold) addr = next_a;
    else begin
      rd = 1'b0;
      wr = 1'b0;
    end
    #1;
    check("done_busy", busy, 1'b0);
    tick();
    check("idle_busy", busy, hold);
    check("idle_rdata", rdata, exp_rd);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] a;
    bit         is_rd;
    exp_rd = 8'h00;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    #2;
    do_reset(2);

    // Write then read back.
    request(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0);
    release_req(1'b0, 8'h00);
    request(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);

    // Latched address: live ADDRESS moves to 8'h20, which holds a different value.
    request(1'b0, 1'b1, 8'h20, 8'h77, 1'b0);
    release_req(1'b0, 8'h00);
    request(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);
    request(1'b1, 1'b0, 8'h10, 8'h00, 1'b1);
    release_req(1'b0, 8'h00);

    // Illegal READ+WRITE is ignored entirely.
    request(1'b0, 1'b1, 8'h30, 8'h12, 1'b0);
    release_req(1'b0, 8'h00);
    rd    = 1'b1;
    wr    = 1'b1;
    addr  = 8'h30;
    wdata = 8'hFF;
    #1;
    check("illegal_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("illegal_busy_hold", busy, 1'b0);
      check("illegal_rdata", rdata, exp_rd);
    end
    rd = 1'b0;
    wr = 1'b0;
    tick();
    request(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);

    // Reset two cycles into a write drops the write.
    request(1'b0, 1'b1, 8'h40, 8'h81, 1'b0);
    release_req(1'b0, 8'h00);
    rd    = 1'b0;
    wr    = 1'b1;
    addr  = 8'h40;
    wdata = 8'h3C;
    #1;
    check("rstmid_req_busy", busy, 1'b1);
    tick();
    tick();
    tick();
    do_reset(1);
    check("post_rst_busy", busy, 1'b0);
    request(1'b1, 1'b0, 8'h40, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);
`ifdef DMEM_CLEAR_ON_RESET_EN
    request(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);
`endif

    // Back-to-back reads with READ held through DONE.
    request(1'b0, 1'b1, 8'h01, 8'h5A, 1'b0);
    release_req(1'b0, 8'h00);
    request(1'b0, 1'b1, 8'h02, 8'hC3, 1'b0);
    release_req(1'b0, 8'h00);
    request(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    release_req(1'b1, 8'h02);
    request(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
    release_req(1'b0, 8'h00);

    // Randomized traffic over a small address window; reads only hit known words.
    for (int n = 0; n < 30; n++) begin
      a     = 8'h80 + 8'($urandom_range(0, 15));
      v     = 8'($urandom);
      is_rd = ($urandom_range(0, 1) == 1) && known[a];
      if (is_rd) request(1'b1, 1'b0, a, v, $urandom_range(0, 1) == 1);
      else       request(1'b0, 1'b1, a, v, $urandom_range(0, 1) == 1);
      release_req(1'b0, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
